// File: rtl/adder_arb_pkg.sv
// Shared definitions for the two-requester arbitrated 6-bit adder:
// FSM state encoding, operand/sum widths, requester count.
package adder_arb_pkg;

  localparam int OP_W  = 6;
  localparam int SUM_W = 7;
  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot_req(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/adder_6bits.sv
// Combinational 6-bit unsigned adder; carry lands in bit 6 of the sum.
// Zero latency, no flow control.
module adder_6bits
  import adder_arb_pkg::*;
(
  input  logic [OP_W-1:0]  i_a,
  input  logic [OP_W-1:0]  i_b,
  output logic [SUM_W-1:0] o_s
);

  assign o_s = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/adder_6bits_arbiter.sv
// Two requesters share one adder: accept -> rsp_valid in 2 cycles, result held until owner's rsp_ready.
// Fixed priority (req0) by default; ADDER_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module adder_6bits_arbiter
  import adder_arb_pkg::*;
#(
  parameter int P_CNT_W = 8
) (
  input  logic               i_w_clk,
  input  logic               i_w_reset,
  input  logic [N_REQ-1:0]   i_w_req_valid,
  input  logic [OP_W-1:0]    i_w_a0,
  input  logic [OP_W-1:0]    i_w_b0,
  input  logic [OP_W-1:0]    i_w_a1,
  input  logic [OP_W-1:0]    i_w_b1,
  output logic [N_REQ-1:0]   o_w_req_ready,
  output logic [N_REQ-1:0]   o_w_rsp_valid,
  input  logic [N_REQ-1:0]   i_w_rsp_ready,
  output logic [SUM_W-1:0]   o_w_rsp_s,
  output logic               o_w_busy,
  output logic [P_CNT_W-1:0] o_w_ops_count
);

  localparam logic [P_CNT_W-1:0] LP_CNT_ONE = 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OP_W-1:0]    r_a;
  logic [OP_W-1:0]    r_b;
  logic               r_owner;
  logic [SUM_W-1:0]   r_sum;
  logic [SUM_W-1:0]   w_sum;
  logic [P_CNT_W-1:0] r_cnt;
  logic               w_grant;
  logic               w_acc;
  logic               w_rsp_done;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  always_comb w_grant = (&i_w_req_valid) ? r_ptr : i_w_req_valid[1];

  // After each served response the other requester gets priority on a tie
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      r_ptr <= 1'b0;
    end else if (w_rsp_done) begin
      r_ptr <= ~r_owner;
    end
  end
`else
  always_comb w_grant = ~i_w_req_valid[0];
`endif

  adder_6bits u_adder (
    .i_a (r_a),
    .i_b (r_b),
    .o_s (w_sum)
  );

  always_comb begin
    w_state_nxt   = r_state;
    o_w_req_ready = '0;
    o_w_rsp_valid = '0;
    w_acc         = 1'b0;
    w_rsp_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_w_req_valid) begin
          o_w_req_ready = onehot_req(w_grant);
          w_acc         = 1'b1;
          w_state_nxt   = ST_CALC;
        end
      end
      ST_CALC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        o_w_rsp_valid = onehot_req(r_owner);
        if (i_w_rsp_ready[r_owner]) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // No handshake is offered while reset is asserted
    if (i_w_reset) begin
      o_w_req_ready = '0;
      o_w_rsp_valid = '0;
    end
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_owner <= 1'b0;
      r_sum   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        r_a     <= w_grant ? i_w_a1 : i_w_a0;
        r_b     <= w_grant ? i_w_b1 : i_w_b0;
        r_owner <= w_grant;
      end
      if (r_state == ST_CALC) begin
        r_sum <= w_sum;
      end
      if (w_rsp_done) begin
        r_cnt <= r_cnt + LP_CNT_ONE;
      end
    end
  end

  assign o_w_busy      = (r_state != ST_IDLE);
  assign o_w_rsp_s     = r_sum;
  assign o_w_ops_count = r_cnt;

endmodule

// File: tb/tb_adder_6bits_arbiter.sv
// Scenario bench for adder_6bits_arbiter; a negedge monitor queues expected sums at accept
// and retires them at response handshake. Grant order follows ADDER_ARB_ROUND_ROBIN_EN.
module tb_adder_6bits_arbiter;

  logic       clk;
  logic       i_w_reset;
  logic [1:0] i_w_req_valid;
  logic [5:0] i_w_a0, i_w_b0, i_w_a1, i_w_b1;
  logic [1:0] o_w_req_ready;
  logic [1:0] o_w_rsp_valid;
  logic [1:0] i_w_rsp_ready;
  logic [6:0] o_w_rsp_s;
  logic       o_w_busy;
  logic [7:0] o_w_ops_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb_q[$];

  adder_6bits_arbiter #(.P_CNT_W(8)) dut (
    .i_w_clk       (clk),
    .i_w_reset     (i_w_reset),
    .i_w_req_valid (i_w_req_valid),
    .i_w_a0        (i_w_a0),
    .i_w_b0        (i_w_b0),
    .i_w_a1        (i_w_a1),
    .i_w_b1        (i_w_b1),
    .o_w_req_ready (o_w_req_ready),
    .o_w_rsp_valid (o_w_rsp_valid),
    .i_w_rsp_ready (i_w_rsp_ready),
    .o_w_rsp_s     (o_w_rsp_s),
    .o_w_busy      (o_w_busy),
    .o_w_ops_count (o_w_ops_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: push {owner, a+b} at accept, compare at response handshake
  always @(negedge clk) begin
    logic       id;
    logic [6:0] s;
    logic [7:0] exp_v;
    if (!i_w_reset) begin
      if (|(i_w_req_valid & o_w_req_ready)) begin
        id = o_w_req_ready[1];
        s  = id ? ({1'b0, i_w_a1} + {1'b0, i_w_b1}) : ({1'b0, i_w_a0} + {1'b0, i_w_b0});
        sb_q.push_back({id, s});
      end
      if (|(o_w_rsp_valid & i_w_rsp_ready)) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected_rsp: rsp_valid=%b rsp_s=%0d, required no response", o_w_rsp_valid, o_w_rsp_s);
        end else begin
          exp_v = sb_q.pop_front();
          if ({o_w_rsp_valid, o_w_rsp_s} !== {exp_v[7] ? 2'b10 : 2'b01, exp_v[6:0]}) begin
            n_errors++;
            $display("FAIL sb_rsp: rsp_valid=%b rsp_s=%0d, required rsp_valid=%b rsp_s=%0d",
                     o_w_rsp_valid, o_w_rsp_s, exp_v[7] ? 2'b10 : 2'b01, exp_v[6:0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int id, input logic [5:0] a, input logic [5:0] b);
    bit ok;
    step();
    i_w_req_valid = (id == 1) ? 2'b10 : 2'b01;
    if (id == 1) begin i_w_a1 = a; i_w_b1 = b; end
    else         begin i_w_a0 = a; i_w_b0 = b; end
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_w_req_ready[id]) begin ok = 1; break; end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL op_accept_timeout: req%0d ready=%b, required grant within 10 cycles", id, o_w_req_ready);
    end
    step();
    i_w_req_valid = 2'b00;
    i_w_rsp_ready = (id == 1) ? 2'b10 : 2'b01;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!o_w_busy) begin ok = 1; break; end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL op_done_timeout: req%0d busy=%b, required idle within 10 cycles", id, o_w_busy);
    end
    i_w_rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    i_w_reset = 1'b1; i_w_req_valid = 2'b00; i_w_rsp_ready = 2'b00;
    i_w_a0 = '0; i_w_b0 = '0; i_w_a1 = '0; i_w_b1 = '0;
    step(); step();
    @(negedge clk);
    n_checks++;
    if ({o_w_req_ready, o_w_rsp_valid, o_w_rsp_s, o_w_busy, o_w_ops_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b s=%0d busy=%b cnt=%0d, required all 0",
               o_w_req_ready, o_w_rsp_valid, o_w_rsp_s, o_w_busy, o_w_ops_count);
    end
    step();
    i_w_req_valid = 2'b11;
    @(negedge clk);
    n_checks++;
    if (o_w_req_ready !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_blocks_ready: ready=%b, required 00", o_w_req_ready);
    end
    step();
    i_w_reset = 1'b0; i_w_req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (o_w_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_no_accept: busy=%b, required 0", o_w_busy);
    end
  endtask

  task automatic test_basic();
    step();
    i_w_req_valid = 2'b01; i_w_a0 = 6'd5; i_w_b0 = 6'd7;
    @(negedge clk);
    n_checks++;
    if (o_w_req_ready !== 2'b01) begin
      n_errors++; $display("FAIL basic_ready_c0: ready=%b, required 01", o_w_req_ready);
    end
    step();
    i_w_req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({o_w_busy, o_w_rsp_valid} !== 3'b100) begin
      n_errors++; $display("FAIL basic_calc_c1: busy=%b rsp_valid=%b, required 1 00", o_w_busy, o_w_rsp_valid);
    end
    step();
    i_w_rsp_ready = 2'b01;
    @(negedge clk);
    n_checks++;
    if ({o_w_rsp_valid, o_w_rsp_s} !== {2'b01, 7'd12}) begin
      n_errors++; $display("FAIL basic_rsp_c2: rsp_valid=%b s=%0d, required 01 12", o_w_rsp_valid, o_w_rsp_s);
    end
    step();
    i_w_rsp_ready = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({o_w_busy, o_w_ops_count} !== {1'b0, 8'd1}) begin
      n_errors++; $display("FAIL basic_count: busy=%b cnt=%0d, required 0 1", o_w_busy, o_w_ops_count);
    end
  endtask

  task automatic test_req1_max();
    step();
    i_w_req_valid = 2'b10; i_w_a1 = 6'd63; i_w_b1 = 6'd63;
    @(negedge clk);
    n_checks++;
    if (o_w_req_ready !== 2'b10) begin
      n_errors++; $display("FAIL req1_ready: ready=%b, required 10", o_w_req_ready);
    end
    step();
    i_w_req_valid = 2'b00;
    step();
    i_w_rsp_ready = 2'b01;
    @(negedge clk);
    n_checks++;
    if ({o_w_rsp_valid, o_w_rsp_s} !== {2'b10, 7'd126}) begin
      n_errors++; $display("FAIL req1_rsp: rsp_valid=%b s=%0d, required 10 126", o_w_rsp_valid, o_w_rsp_s);
    end
    step();
    i_w_rsp_ready = 2'b10;
    @(negedge clk);
    n_checks++;
    if (o_w_rsp_valid !== 2'b10) begin
      n_errors++; $display("FAIL req1_nonowner_ignored: rsp_valid=%b, required 10", o_w_rsp_valid);
    end
    step();
    i_w_rsp_ready = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({o_w_busy, o_w_ops_count} !== {1'b0, 8'd2}) begin
      n_errors++; $display("FAIL req1_count: busy=%b cnt=%0d, required 0 2", o_w_busy, o_w_ops_count);
    end
  endtask

  task automatic test_hold();
    step();
    i_w_req_valid = 2'b01; i_w_a0 = 6'd1; i_w_b0 = 6'd2;
    step();
    i_w_req_valid = 2'b00;
    step();
    i_w_req_valid = 2'b11; i_w_a0 = 6'd50; i_w_a1 = 6'd60;
    @(negedge clk);
    n_checks++;
    if ({o_w_rsp_valid, o_w_rsp_s} !== {2'b01, 7'd3}) begin
      n_errors++; $display("FAIL hold_first: rsp_valid=%b s=%0d, required 01 3", o_w_rsp_valid, o_w_rsp_s);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      i_w_a0 = 6'(k * 9);
      @(negedge clk);
      n_checks++;
      if ({o_w_rsp_valid, o_w_rsp_s, o_w_req_ready} !== {2'b01, 7'd3, 2'b00}) begin
        n_errors++;
        $display("FAIL hold_cycle%0d: rsp_valid=%b s=%0d ready=%b, required 01 3 00",
                 k, o_w_rsp_valid, o_w_rsp_s, o_w_req_ready);
      end
    end
    step();
    i_w_rsp_ready = 2'b01; i_w_req_valid = 2'b00;
    step();
    i_w_rsp_ready = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({o_w_busy, o_w_ops_count} !== {1'b0, 8'd3}) begin
      n_errors++; $display("FAIL hold_release: busy=%b cnt=%0d, required 0 3", o_w_busy, o_w_ops_count);
    end
  endtask

  task automatic test_reset_mid();
    step();
    i_w_req_valid = 2'b01; i_w_a0 = 6'd9; i_w_b0 = 6'd9;
    step();
    i_w_req_valid = 2'b00; i_w_reset = 1'b1; i_w_rsp_ready = 2'b11;
    @(negedge clk);
    n_checks++;
    if (o_w_busy !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_in_calc: busy=%b, required 1", o_w_busy);
    end
    step();
    i_w_reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_checks++;
    if ({o_w_req_ready, o_w_rsp_valid, o_w_rsp_s, o_w_busy, o_w_ops_count} !== '0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: ready=%b rsp_valid=%b s=%0d busy=%b cnt=%0d, required all 0",
               o_w_req_ready, o_w_rsp_valid, o_w_rsp_s, o_w_busy, o_w_ops_count);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      n_checks++;
      if ({o_w_rsp_valid, o_w_ops_count} !== 10'd0) begin
        n_errors++;
        $display("FAIL rstmid_no_rsp%0d: rsp_valid=%b cnt=%0d, required 00 0", k, o_w_rsp_valid, o_w_ops_count);
      end
    end
    i_w_rsp_ready = 2'b00;
  endtask

  task automatic test_arbitration();
    int   n_g;
    logic grants[4];
    logic exp_g;
    bit   ok;
    step();
    i_w_a0 = 6'd10; i_w_b0 = 6'd20; i_w_a1 = 6'd33; i_w_b1 = 6'd44;
    i_w_req_valid = 2'b11; i_w_rsp_ready = 2'b11;
    n_g = 0;
    for (int c = 0; c < 40 && n_g < 4; c++) begin
      @(negedge clk);
      if (o_w_req_ready != 2'b00) begin
        grants[n_g] = o_w_req_ready[1];
        n_g++;
      end
      step();
    end
    i_w_req_valid = 2'b00;
    n_checks++;
    if (n_g != 4) begin
      n_errors++; $display("FAIL arb_grant_timeout: grants=%0d, required 4", n_g);
    end
    for (int g = 0; g < n_g; g++) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      exp_g = (g % 2) == 1;
`else
      exp_g = 1'b0;
`endif
      n_checks++;
      if (grants[g] !== exp_g) begin
        n_errors++; $display("FAIL arb_grant%0d: granted req%0d, required req%0d", g, grants[g], exp_g);
      end
    end
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!o_w_busy) begin ok = 1; break; end
      step();
    end
    i_w_rsp_ready = 2'b00;
    n_checks++;
    if (!ok || o_w_ops_count !== 8'd4) begin
      n_errors++; $display("FAIL arb_done: busy=%b cnt=%0d, required 0 4", o_w_busy, o_w_ops_count);
    end
  endtask

  task automatic test_wrap();
    step();
    i_w_reset = 1'b1;
    step();
    i_w_reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      do_op(i % 2, 6'(i), 6'(i * 5));
      if (i == 254) begin
        n_checks++;
        if (o_w_ops_count !== 8'd255) begin
          n_errors++; $display("FAIL wrap_255: cnt=%0d, required 255", o_w_ops_count);
        end
      end
    end
    n_checks++;
    if (o_w_ops_count !== 8'd0) begin
      n_errors++; $display("FAIL wrap_0: cnt=%0d, required 0", o_w_ops_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req1_max();
    test_hold();
    test_reset_mid();
    test_arbitration();
    test_wrap();
    step();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("FAIL sb_leftover: pending=%0d, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
